// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a producer and the UART transmitter.
//   tx_data  [7:0] byte to send, sampled by the transmitter only on accept
//   tx_valid       producer has a byte
//   tx_ready       transmitter can take a byte this cycle
// Modports: master = byte producer, slave = transmitter.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART serial transmitter, LSB-first frame:
//   start bit, 8 data bits, optional parity bit, STOP_BITS stop bits.
//   The line idles high. Each bit lasts CLKS_PER_BIT clk cycles.
// Optional feature macro: UART_TX_PARITY_EN (inserts the parity bit; parity
//   sense from PARITY_ODD, 0 = even, 1 = odd). Undefined: 8N1 / 8N2 only.
// Ports:
//   clk      system clock, posedge
//   reset    asynchronous reset, active-high
//   bus      uart_tx_if.slave: tx_data / tx_valid in, tx_ready out
//   tx       serial line, registered
//   tx_busy  frame in progress (= !tx_ready)
//   tx_done  one-cycle pulse in the last clk of the final stop bit
module uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      tx_busy,
    output logic      tx_done
);
    localparam int             CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;       // bit-period counter, 0..CLKS_PER_BIT-1
    logic [2:0]    idx_q, idx_d;       // data bit index
    logic [7:0]    shreg_q, shreg_d;
    logic          stop_q, stop_d;     // which stop bit is on the line
    logic          tx_q, tx_d;
    logic          wrap;
    logic          last_stop;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
    logic par_q, par_d;
`else
    // Parity sense has no meaning without the parity bit.
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    assign wrap      = (cnt_q == CNT_MAX);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        stop_d  = stop_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Bit timer free-runs whenever a frame is on the line.
        if (state_q != IDLE)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_d = START;
                    shreg_d = bus.tx_data;
                    cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^bus.tx_data) ^ PAR_ODD_BIT;
`endif
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (wrap) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;   // 7 -> 0 on exit
                    if (idx_q == 3'd7) begin
                        stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap)
                    state_d = STOP;
            end
`endif
            STOP: begin
                if (wrap) begin
                    if (last_stop)
                        state_d = IDLE;
                    else
                        stop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line register follows the state being entered, so the start
        // bit appears on the edge right after accept.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.tx_ready = (state_q == IDLE);
    assign tx_busy      = (state_q != IDLE);
    assign tx_done      = (state_q == STOP) && wrap && last_stop;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx (CLKS_PER_BIT=8, STOP_BITS=1).
// With UART_TX_PARITY_EN a second instance (PARITY_ODD=1) is added and the
// monitored signals are muxed by sel.
module tb_uart_tx;
    localparam int CPB   = 8;
    localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB    = 1;
`else
    localparam int PB    = 0;
`endif
    localparam int NBITS = 9 + PB + STOPB;
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d;
    logic       v;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_if bus0 ();
    assign bus0.tx_data  = d;
    assign bus0.tx_valid = v;
    logic tx0, busy0, done0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .tx(tx0), .tx_busy(busy0), .tx_done(done0));

    logic tx_m, rdy_m, busy_m, done_m;
`ifdef UART_TX_PARITY_EN
    logic sel = 1'b0;
    uart_tx_if bus1 ();
    assign bus1.tx_data  = d;
    assign bus1.tx_valid = v;
    logic tx1, busy1, done1;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .tx(tx1), .tx_busy(busy1), .tx_done(done1));

    assign tx_m   = sel ? tx1 : tx0;
    assign rdy_m  = sel ? bus1.tx_ready : bus0.tx_ready;
    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;
`else
    assign tx_m   = tx0;
    assign rdy_m  = bus0.tx_ready;
    assign busy_m = busy0;
    assign done_m = done0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"},    {31'd0, tx_m},   32'd1);
        chk({tag, "_ready"}, {31'd0, rdy_m},  32'd1);
        chk({tag, "_busy"},  {31'd0, busy_m}, 32'd0);
        chk({tag, "_done"},  {31'd0, done_m}, 32'd0);
    endtask

    // Present a byte at a negedge; returns at the negedge of frame cycle 0.
    task automatic start(input logic [7:0] b);
        d = b;
        v = 1'b1;
        chk("ready_at_offer", {31'd0, rdy_m}, 32'd1);
        @(negedge clk);
    endtask

    // Walks one whole frame from cycle 0, checking the line every clk against
    // the frame built from exp, and returns mid-bit samples in line.
    task automatic frame(input logic [7:0] exp, input logic odd, input bit drop_v,
                         input bit mid_change, input logic [7:0] mid_d,
                         output logic [11:0] line);
        logic [11:0] lv;
        lv    = '1;
        line  = '1;
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = exp[i];
        if (PB == 1) lv[9] = (^exp) ^ odd;
        for (int c = 0; c < FRAME; c++) begin
            if (c == 0 && drop_v) v = 1'b0;
            if (c == 20 && mid_change) d = mid_d;
            if (c == 30 && mid_change) v = 1'b1;   // ignored while busy
            if (c == 31 && mid_change && drop_v) v = 1'b0;
            chk("tx_level", {31'd0, tx_m},   {31'd0, lv[c/CPB]});
            chk("tx_done",  {31'd0, done_m}, (c == FRAME-1) ? 32'd1 : 32'd0);
            chk("busy",     {31'd0, busy_m}, 32'd1);
            chk("ready",    {31'd0, rdy_m},  32'd0);
            if (c % CPB == CPB/2) line[c/CPB] = tx_m;
            @(negedge clk);
        end
        // One idle cycle with the line high always follows the last stop bit.
        check_idle("post_frame");
    endtask

    logic [11:0] ln;

    initial begin
        reset = 1'b1;
        d     = 8'h00;
        v     = 1'b0;
        @(negedge clk);
        check_idle("in_reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: idle for 100 cycles with no request
        for (int i = 0; i < 100; i++) begin
            check_idle("idle100");
            @(negedge clk);
        end

        // 2: single 0xA5 frame, line 0,1,0,1,0,0,1,0,1,1
        start(8'hA5);
        frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, ln);
        chk("A5_line",   {23'd0, ln[8:0]}, 32'b1_0100_1010);
        chk("A5_stop",   {31'd0, ln[NBITS-1]}, 32'd1);
        chk("A5_decode", {24'd0, ln[8:1]}, 32'hA5);
        repeat (3) @(negedge clk);

        // 3: back-to-back 0x00 then 0xFF with tx_valid held high; data for
        //    the second byte is changed while the first frame is busy
        start(8'h00);
        frame(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, ln);
        chk("b2b_first_line", {23'd0, ln[8:0]}, 32'h000);
        @(negedge clk);                     // accept happened in the idle cycle
        frame(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, ln);
        chk("b2b_second_line", {23'd0, ln[8:0]}, 32'b1_1111_1110);
        repeat (2) @(negedge clk);

        // 4: data and valid wiggled mid-frame are ignored
        start(8'h3C);
        frame(8'h3C, 1'b0, 1'b1, 1'b1, 8'hC3, ln);
        chk("busy_change_decode", {24'd0, ln[8:1]}, 32'h3C);
        v = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("after_busy_change");

        // 5: reset during data bit 4 of 0x5A, then a clean 0x81 frame
        start(8'h5A);
        v = 1'b0;
        repeat (42) @(negedge clk);
        chk("5A_bit4_ready", {31'd0, rdy_m}, 32'd0);
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check_idle("no_resume");
            @(negedge clk);
        end
        start(8'h81);
        frame(8'h81, 1'b0, 1'b1, 1'b0, 8'h00, ln);
        chk("81_decode", {24'd0, ln[8:1]}, 32'h81);
        repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        // 6: even parity of 0x07, odd parity of 0xA5, both 88-cycle frames
        sel = 1'b0;
        start(8'h07);
        frame(8'h07, 1'b0, 1'b1, 1'b0, 8'h00, ln);
        chk("07_decode", {24'd0, ln[8:1]}, 32'h07);
        chk("07_even_parity", {31'd0, ln[9]}, 32'd1);
        repeat (2) @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        start(8'hA5);
        frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, ln);
        chk("A5_decode_odd", {24'd0, ln[8:1]}, 32'hA5);
        chk("A5_odd_parity", {31'd0, ln[9]}, 32'd1);
        repeat (2) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART serial transmitter; the transmit-side counterpart of the team's receiver datapath.
- Accepts a byte over a valid/ready handshake and shifts it out as an LSB-first frame: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Line idles high.
- Bit period is generated internally as a fixed number of clk cycles, matching the receiver's 8-clock sampling window by default.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit; legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk       input   1  system clock; all logic on posedge.
- reset     input   1  asynchronous reset, active-high.
- tx_data   input   8  byte to transmit; sampled only on handshake.
- tx_valid  input   1  tx_data is valid.
- tx_ready  output  1  block can accept a byte this cycle.
- tx        output  1  serial line out, registered.
- tx_busy   output  1  frame in progress.
- tx_done   output  1  one-cycle pulse in the last clk of the final stop bit.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values (asynchronous, immediate): tx=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters 0, shift register 0.
- Reset mid-frame aborts the frame; tx returns to 1 immediately. No partial frame resumes after reset deasserts.
- FSM states: IDLE, START, DATA, PARITY (present only with UART_TX_PARITY_EN), STOP.
- Handshake: accept occurs on the clk edge where tx_valid=1 and tx_ready=1. tx_ready is 1 only in IDLE.
- On accept: latch tx_data into the shift register, compute parity if enabled, and go to START.
- Changes on tx_data or tx_valid while busy are ignored.
- tx_valid may drop before accept with no effect.
- Timing: tx is registered.
  - tx goes low on the edge after accept, i.e. the first cycle tx_ready=0.
  - Each bit holds for exactly CLKS_PER_BIT cycles, timed by the bit-period counter. That counter counts 0..CLKS_PER_BIT-1 and advances state on wrap.
- START: tx=0 for one bit period, then go to DATA with bit index 0.
- DATA: tx = shift_reg[0] (LSB first).
  - At each bit-period wrap: shift right, increment the 3-bit bit index.
  - After index 7 completes, go to PARITY if enabled, otherwise STOP.
- PARITY: tx = XOR of the latched byte, inverted when PARITY_ODD=1; held for one bit period, then go to STOP.
- STOP: tx=1 for STOP_BITS bit periods.
  - tx_done=1 in the final clk of the last stop period.
  - Next cycle: IDLE, tx_ready=1, tx_busy=0.
- tx_busy = !tx_ready.
- Frame length from the first start cycle to the end of the last stop cycle:
  - (1 + 8 + STOP_BITS) × CLKS_PER_BIT cycles without parity.
  - One extra CLKS_PER_BIT with parity.
- Back-to-back transfers: if tx_valid is held high, accept occurs in the first IDLE cycle after tx_done. Between frames the line stays at 1 for exactly one extra clk beyond the stop bits; no other gap is permitted.
- Counter widths: the bit-period counter is $clog2(CLKS_PER_BIT) bits and never exceeds CLKS_PER_BIT-1. The bit index wraps 7→0 only at the DATA exit.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP and carries even or odd parity according to PARITY_ODD. The frame becomes 11 or 12 bits.
- Undefined: the PARITY state, parity register and parity logic are absent. The frame is 8N1 or 8N2, and PARITY_ODD has no effect.

Test Plan:
1. Reset release, tx_valid=0 for 100 cycles -> tx=1, tx_ready=1, tx_busy=0, tx_done never pulses.
2. CLKS_PER_BIT=8, STOP_BITS=1, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held for 8 cycles. tx_done pulses in cycle 80 after the start cycle. Scoreboard decodes 0xA5.
3. Back-to-back 0x00 then 0xFF with tx_valid held high -> the second start bit begins exactly 1 clk after the first frame's tx_done cycle. Line levels are 0×9 bits then 1, followed by 0 then 1×9 bits.
4. Change tx_data from 0x3C to 0xC3 mid-frame while busy -> the transmitted byte remains 0x3C. tx_ready stays 0 until after tx_done.
5. Assert reset during DATA bit 4 of 0x5A -> tx=1 and tx_ready=1 asynchronously. After release, sending 0x81 gives a clean frame decoding 0x81.
6. UART_TX_PARITY_EN with PARITY_ODD=0, send 0x07, then with PARITY_ODD=1, send 0xA5 -> parity bit 1 for 0x07 (three ones, even parity). Parity bit 1 for 0xA5 (four ones, odd parity). Each frame is 11 bit periods (88 cycles).
